// File: rtl/pll_ps_pkg.sv
// Shared state encodings, error codes and channel count for the PLL fine phase-shift sequencer.
package pll_ps_pkg;

    localparam int unsigned NUM_CLKC = 7;

    typedef logic [2:0] ps_state_t;

    localparam ps_state_t StIdle  = 3'd0;
    localparam ps_state_t StCheck = 3'd1;
    localparam ps_state_t StSetup = 3'd2;
    localparam ps_state_t StStep  = 3'd3;
    localparam ps_state_t StWait  = 3'd4;
    localparam ps_state_t StGap   = 3'd5;
    localparam ps_state_t StFin   = 3'd6;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CLKSEL = 2'd1;
    localparam logic [1:0] ERR_NOLOCK = 2'd2;
    localparam logic [1:0] ERR_TMO    = 2'd3;

endpackage

// File: rtl/pll_ps_done_sync.sv
// Two-flop synchronizer plus registered rising-edge detect for an asynchronous psdone.
module pll_ps_done_sync (
    input  logic psclk_i,
    input  logic rstn_i,
    input  logic psdone_i,
    output logic done_pulse_o
);

    logic sync1_q, sync2_q, prev_q, pulse_q;

    always_ff @(posedge psclk_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= psdone_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign done_pulse_o = pulse_q;

endmodule

// File: rtl/pll_fine_phase_ctrl.sv
// Sequences PLL dynamic phase-shift steps per command and tracks each channel's phase position.
// Define PLL_PS_DONE_SYNC_EN when psdone is asynchronous to psclk.
module pll_fine_phase_ctrl
    import pll_ps_pkg::*;
#(
    parameter int unsigned PHASE_STEPS = 64,
    parameter int unsigned PHASE_W     = 6,
    parameter int unsigned STEP_W      = 8,
    parameter int unsigned DONE_TMO    = 255,
    parameter int unsigned GAP_CYC     = 2
) (
    input  logic                        psclk,
    input  logic                        rstn,
    input  logic                        pll_lock,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_clksel,
    input  logic                        req_down,
    input  logic [STEP_W-1:0]           req_steps,
    output logic                        cmd_done,
    output logic                        cmd_err,
    output logic [1:0]                  err_code,
    output logic                        busy,
    output logic [NUM_CLKC*PHASE_W-1:0] phase_pos,
    output logic [2:0]                  psclksel,
    output logic                        psdown,
    output logic                        psstep,
    input  logic                        psdone
);

    localparam int unsigned TMO_W = $clog2(DONE_TMO + 1);
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    // Loaded so that a timeout's cmd_done lands exactly DONE_TMO cycles after psstep.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(DONE_TMO - 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    ps_state_t                   state_q, state_d;
    logic [2:0]                  clksel_q, clksel_d;
    logic                        down_q, down_d;
    logic [STEP_W-1:0]           rem_q, rem_d;
    logic [TMO_W-1:0]            tmo_q, tmo_d;
    logic [GAP_W-1:0]            gap_q, gap_d;
    logic [1:0]                  err_q, err_d;
    logic [NUM_CLKC*PHASE_W-1:0] pos_q, pos_d;
    logic                        ready_q;
    logic                        done_pulse;
    logic                        drive_ps;

`ifdef PLL_PS_DONE_SYNC_EN
    pll_ps_done_sync u_done_sync (
        .psclk_i      (psclk),
        .rstn_i       (rstn),
        .psdone_i     (psdone),
        .done_pulse_o (done_pulse)
    );
`else
    assign done_pulse = psdone;
`endif

    function automatic logic [PHASE_W-1:0] next_pos(input logic [PHASE_W-1:0] p, input logic dn);
        if (dn) begin
            return (p == PHASE_W'(PHASE_STEPS - 1)) ? '0 : p + PHASE_W'(1);
        end
        return (p == '0) ? PHASE_W'(PHASE_STEPS - 1) : p - PHASE_W'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        clksel_d = clksel_q;
        down_d   = down_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        err_d    = err_q;
        pos_d    = pos_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    clksel_d = req_clksel;
                    down_d   = req_down;
                    rem_d    = req_steps;
                    err_d    = ERR_NONE;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (clksel_q >= 3'(NUM_CLKC)) begin
                    err_d   = ERR_CLKSEL;
                    state_d = StFin;
                end else if (!pll_lock) begin
                    err_d   = ERR_NOLOCK;
                    state_d = StFin;
                end else if (rem_q == '0) begin
                    state_d = StFin;
                end else begin
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StStep;
            StStep: begin
                tmo_d   = TMO_LOAD;
                state_d = StWait;
            end
            StWait: begin
                // psdone wins over a simultaneous timeout.
                if (done_pulse) begin
                    for (int n = 0; n < int'(NUM_CLKC); n++) begin
                        if (clksel_q == 3'(n)) begin
                            pos_d[n*PHASE_W +: PHASE_W] = next_pos(pos_q[n*PHASE_W +: PHASE_W], down_q);
                        end
                    end
                    rem_d   = rem_q - STEP_W'(1);
                    gap_d   = GAP_LOAD;
                    state_d = StGap;
                end else if (tmo_q == '0) begin
                    err_d   = ERR_TMO;
                    state_d = StFin;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            StGap: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (rem_q == '0) begin
                    state_d = StFin;
                end else if (!pll_lock) begin
                    err_d   = ERR_NOLOCK;
                    state_d = StFin;
                end else begin
                    state_d = StStep;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge psclk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            clksel_q <= '0;
            down_q   <= 1'b0;
            rem_q    <= '0;
            tmo_q    <= '0;
            gap_q    <= '0;
            err_q    <= ERR_NONE;
            pos_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            clksel_q <= clksel_d;
            down_q   <= down_d;
            rem_q    <= rem_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
            pos_q    <= pos_d;
            ready_q  <= 1'b1;
        end
    end

    assign drive_ps  = (state_q == StSetup) || (state_q == StStep) ||
                       (state_q == StWait)  || (state_q == StGap);
    assign req_ready = ready_q && (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign psstep    = (state_q == StStep);
    assign psclksel  = drive_ps ? clksel_q : 3'd0;
    assign psdown    = drive_ps & down_q;
    assign cmd_done  = (state_q == StFin);
    assign cmd_err   = cmd_done && (err_q != ERR_NONE);
    assign err_code  = cmd_done ? err_q : ERR_NONE;
    assign phase_pos = pos_q;

endmodule

// File: tb/tb_pll_fine_phase_ctrl.sv
// Self-checking bench for pll_fine_phase_ctrl with an in-bench PLL responder and position model.
module tb_pll_fine_phase_ctrl;

    localparam int PHASE_STEPS = 64;
    localparam int PHASE_W     = 6;
    localparam int DONE_TMO    = 255;
    localparam int GAP_CYC     = 2;
    localparam int NCH         = 7;

    logic       psclk      = 1'b0;
    logic       rstn       = 1'b0;
    logic       pll_lock   = 1'b1;
    logic       req_valid  = 1'b0;
    logic [2:0] req_clksel = 3'd0;
    logic       req_down   = 1'b0;
    logic [7:0] req_steps  = 8'd0;
    logic       psdone     = 1'b0;

    logic                   req_ready, cmd_done, cmd_err, busy, psdown, psstep;
    logic [1:0]             err_code;
    logic [2:0]             psclksel;
    logic [NCH*PHASE_W-1:0] phase_pos;

    int n_tests = 0;
    int n_fail  = 0;
    int model_pos[NCH];

    always #5 psclk = ~psclk;

    pll_fine_phase_ctrl dut (
        .psclk      (psclk),
        .rstn       (rstn),
        .pll_lock   (pll_lock),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_clksel (req_clksel),
        .req_down   (req_down),
        .req_steps  (req_steps),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err),
        .err_code   (err_code),
        .busy       (busy),
        .phase_pos  (phase_pos),
        .psclksel   (psclksel),
        .psdown     (psdown),
        .psstep     (psstep),
        .psdone     (psdone)
    );

    // Issues one command and plays the PLL: psdone returns dly cycles after each psstep
    // (dly 0 = never). drop_at > 0 drops pll_lock right after that psstep.
    task automatic do_cmd(input logic [2:0] sel, input logic dn, input logic [7:0] st,
                          input int dly, input int drop_at,
                          output int n_step, output int lat, output int tmo_lat,
                          output int hold_bad, output logic [1:0] code, output logic err);
        int cnt;
        int cyc;
        int last_step;
        bit done;
        n_step = 0; lat = -1; tmo_lat = -1; hold_bad = 0; code = 2'd0; err = 1'b0;
        cnt = 0; cyc = 0; last_step = -1; done = 0;
        @(negedge psclk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_clksel = sel; req_down = dn; req_steps = st;
        @(negedge psclk);
        req_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 2000) begin
            psdone = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) psdone = 1'b1;
            end
            if (psstep === 1'b1) begin
                n_step++;
                last_step = cyc;
                if (psclksel !== sel || psdown !== dn) hold_bad++;
                cnt = dly;
                if (n_step == drop_at) pll_lock = 1'b0;
            end
            if (psdone && (psclksel !== sel || psdown !== dn)) hold_bad++;
            if (cmd_done === 1'b1) begin
                done = 1;
                lat  = cyc;
                code = err_code;
                err  = cmd_err;
                if (psclksel !== 3'd0 || psdown !== 1'b0) hold_bad++;
                if (last_step >= 0) tmo_lat = cyc - last_step;
            end else begin
                @(negedge psclk);
                cyc++;
            end
        end
        psdone   = 1'b0;
        pll_lock = 1'b1;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_done_bound: no cmd_done within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge psclk);
        n_tests++;
        if ({req_ready, busy, cmd_done, cmd_err, err_code, psstep, psdown, psclksel} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0",
                     {req_ready, busy, cmd_done, cmd_err, err_code, psstep, psdown, psclksel});
        end
        n_tests++;
        if (phase_pos !== '0) begin
            n_fail++;
            $display("FAIL reset_pos: got %h want 0", phase_pos);
        end
        rstn = 1'b1;
        @(negedge psclk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
        for (int n = 0; n < NCH; n++) model_pos[n] = 0;
    endtask

    task automatic test_basic();
        int ns, lat, tl, hb;
        logic [1:0] code;
        logic er;
        do_cmd(3'd2, 1'b1, 8'd3, 4, 0, ns, lat, tl, hb, code, er);
        model_pos[2] = (model_pos[2] + 3) % PHASE_STEPS;
        n_tests++;
        if (ns !== 3) begin n_fail++; $display("FAIL basic_psstep_count: got %0d want 3", ns); end
        n_tests++;
        if (hb !== 0) begin n_fail++; $display("FAIL basic_sel_hold: got %0d bad want 0", hb); end
        n_tests++;
        if (code !== 2'd0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_err: got err=%b code=%0d want 0/0", er, code);
        end
        n_tests++;
        if (lat !== 3 + 3 * (1 + 4 + GAP_CYC)) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want %0d", lat, 3 + 3 * (1 + 4 + GAP_CYC));
        end
        n_tests++;
        if (int'(phase_pos[2*PHASE_W +: PHASE_W]) !== model_pos[2]) begin
            n_fail++;
            $display("FAIL basic_pos: got %0d want %0d", phase_pos[2*PHASE_W +: PHASE_W], model_pos[2]);
        end
    endtask

    task automatic test_wrap();
        int ns, lat, tl, hb;
        logic [1:0] code;
        logic er;
        do_cmd(3'd0, 1'b0, 8'd1, 3, 0, ns, lat, tl, hb, code, er);
        n_tests++;
        if (phase_pos[0 +: PHASE_W] !== 6'd63) begin
            n_fail++;
            $display("FAIL wrap_down_pos: got %0d want 63", phase_pos[0 +: PHASE_W]);
        end
        do_cmd(3'd0, 1'b1, 8'd1, 3, 0, ns, lat, tl, hb, code, er);
        n_tests++;
        if (phase_pos[0 +: PHASE_W] !== 6'd0) begin
            n_fail++;
            $display("FAIL wrap_up_pos: got %0d want 0", phase_pos[0 +: PHASE_W]);
        end
    endtask

    task automatic test_zero_and_badsel();
        int ns, lat, tl, hb;
        logic [1:0] code;
        logic er;
        do_cmd(3'd1, 1'b1, 8'd0, 4, 0, ns, lat, tl, hb, code, er);
        n_tests++;
        if (lat !== 2 || ns !== 0 || code !== 2'd0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_steps: got lat=%0d steps=%0d code=%0d err=%b want 2/0/0/0",
                     lat, ns, code, er);
        end
        do_cmd(3'd7, 1'b0, 8'd4, 4, 0, ns, lat, tl, hb, code, er);
        n_tests++;
        if (lat !== 2 || ns !== 0 || code !== 2'd1 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_clksel: got lat=%0d steps=%0d code=%0d err=%b want 2/0/1/1",
                     lat, ns, code, er);
        end
        @(negedge psclk);
        psdone = 1'b1;
        @(negedge psclk);
        psdone = 1'b0;
        @(negedge psclk);
        for (int n = 0; n < NCH; n++) begin
            n_tests++;
            if (int'(phase_pos[n*PHASE_W +: PHASE_W]) !== model_pos[n]) begin
                n_fail++;
                $display("FAIL stray_psdone_pos%0d: got %0d want %0d",
                         n, phase_pos[n*PHASE_W +: PHASE_W], model_pos[n]);
            end
        end
    endtask

    task automatic test_timeout();
        int ns, lat, tl, hb;
        logic [1:0] code;
        logic er;
        do_cmd(3'd5, 1'b0, 8'd3, 0, 0, ns, lat, tl, hb, code, er);
        n_tests++;
        if (ns !== 1 || code !== 2'd3 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err: got steps=%0d code=%0d err=%b want 1/3/1", ns, code, er);
        end
        n_tests++;
        if (tl !== DONE_TMO) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d want %0d", tl, DONE_TMO);
        end
        n_tests++;
        if (int'(phase_pos[5*PHASE_W +: PHASE_W]) !== model_pos[5]) begin
            n_fail++;
            $display("FAIL timeout_pos: got %0d want %0d", phase_pos[5*PHASE_W +: PHASE_W], model_pos[5]);
        end
    endtask

    task automatic test_lock_drop();
        int ns, lat, tl, hb;
        logic [1:0] code;
        logic er;
        do_cmd(3'd4, 1'b1, 8'd5, 4, 2, ns, lat, tl, hb, code, er);
        model_pos[4] = (model_pos[4] + 2) % PHASE_STEPS;
        n_tests++;
        if (ns !== 2 || code !== 2'd2 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_drop_err: got steps=%0d code=%0d err=%b want 2/2/1", ns, code, er);
        end
        n_tests++;
        if (int'(phase_pos[4*PHASE_W +: PHASE_W]) !== model_pos[4]) begin
            n_fail++;
            $display("FAIL lock_drop_pos: got %0d want %0d", phase_pos[4*PHASE_W +: PHASE_W], model_pos[4]);
        end
    endtask

    task automatic test_random();
        int ns, lat, tl, hb, exp_lat, steps, dly;
        logic [1:0] code;
        logic er;
        logic [2:0] sel;
        logic dn;
        for (int i = 0; i < 10; i++) begin
            sel   = 3'($urandom_range(6, 0));
            dn    = 1'($urandom_range(1, 0));
            steps = $urandom_range(5, 0);
            dly   = $urandom_range(10, 1);
            do_cmd(sel, dn, 8'(steps), dly, 0, ns, lat, tl, hb, code, er);
            for (int s = 0; s < steps; s++) begin
                model_pos[sel] = (model_pos[sel] + (dn ? 1 : PHASE_STEPS - 1)) % PHASE_STEPS;
            end
            exp_lat = (steps == 0) ? 2 : 3 + steps * (1 + dly + GAP_CYC);
            n_tests++;
            if (ns !== steps || lat !== exp_lat || code !== 2'd0 || er !== 1'b0 || hb !== 0) begin
                n_fail++;
                $display("FAIL rand%0d_cmd: got steps=%0d lat=%0d code=%0d hold=%0d want %0d/%0d/0/0",
                         i, ns, lat, code, hb, steps, exp_lat);
            end
            for (int n = 0; n < NCH; n++) begin
                n_tests++;
                if (int'(phase_pos[n*PHASE_W +: PHASE_W]) !== model_pos[n]) begin
                    n_fail++;
                    $display("FAIL rand%0d_pos%0d: got %0d want %0d",
                             i, n, phase_pos[n*PHASE_W +: PHASE_W], model_pos[n]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int guard;
        int ns, lat, tl, hb;
        logic [1:0] code;
        logic er;
        @(negedge psclk);
        req_valid = 1'b1; req_clksel = 3'd3; req_down = 1'b1; req_steps = 8'd4;
        @(negedge psclk);
        req_valid = 1'b0;
        guard = 0;
        while (psstep !== 1'b1 && guard < 20) begin
            @(negedge psclk);
            guard++;
        end
        n_tests++;
        if (psstep !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_psstep: got %b want 1", psstep);
        end
        @(negedge psclk);
        rstn = 1'b0;
        @(negedge psclk);
        n_tests++;
        if ({req_ready, busy, cmd_done, cmd_err, err_code, psstep, psdown, psclksel} !== 10'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b want 0",
                     {req_ready, busy, cmd_done, cmd_err, err_code, psstep, psdown, psclksel});
        end
        n_tests++;
        if (phase_pos !== '0) begin
            n_fail++;
            $display("FAIL midrst_pos: got %h want 0", phase_pos);
        end
        rstn = 1'b1;
        for (int n = 0; n < NCH; n++) model_pos[n] = 0;
        @(negedge psclk);
        n_tests++;
        if (req_ready !== 1'b1 || cmd_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: got ready=%b done=%b want 1/0", req_ready, cmd_done);
        end
        do_cmd(3'd6, 1'b0, 8'd2, 2, 0, ns, lat, tl, hb, code, er);
        n_tests++;
        if (phase_pos[6*PHASE_W +: PHASE_W] !== 6'd62 || ns !== 2 || code !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_after_cmd: got pos=%0d steps=%0d code=%0d want 62/2/0",
                     phase_pos[6*PHASE_W +: PHASE_W], ns, code);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_and_badsel();
        test_timeout();
        test_lock_drop();
        test_random();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_fine_phase_ctrl.md
Name: pll_fine_phase_ctrl

Overview:
- Sequences dynamic fine phase-shift requests into the PLL ps interface (psclksel/psdown/psstep, psdone handshake) for RX LVDS bit-alignment.
- Accepts "shift channel N by K steps up/down" commands from the alignment logic and issues one psstep per step, waiting on psdone between steps.
- Tracks the accumulated phase position of each of the 7 output channels.
- Aborts and flags an error on lock loss or psdone timeout.

Parameters:
- PHASE_STEPS, 64, phase positions per full rotation; position counter wraps modulo this value.
- PHASE_W, 6, width of each position counter; must satisfy 2^PHASE_W >= PHASE_STEPS.
- STEP_W, 8, width of the requested step count.
- DONE_TMO, 255, psclk cycles to wait for psdone before declaring a timeout.
- GAP_CYC, 2, idle cycles inserted after each psdone before the next psstep.

Ports:
- psclk  in  1  Block clock; the same clock drives the PLL psclk pin.
- rstn  in  1  Reset, synchronous, active-low.
- pll_lock  in  1  PLL lock indicator.
- req_valid  in  1  Command valid.
- req_ready  out  1  Block can accept a command.
- req_clksel  in  3  Target channel, 0..6.
- req_down  in  1  1 = shift later (psdown), 0 = shift earlier.
- req_steps  in  STEP_W  Number of steps to issue.
- cmd_done  out  1  One-cycle pulse when a command completes, with or without error.
- cmd_err  out  1  Valid only together with cmd_done: 1 = command aborted.
- err_code  out  2  Valid with cmd_done: 0 none, 1 bad clksel, 2 no lock, 3 timeout.
- busy  out  1  FSM not in IDLE.
- phase_pos  out  7*PHASE_W  Per-channel position; channel n occupies bits [n*PHASE_W +: PHASE_W].
- psclksel  out  3  To PLL.
- psdown  out  1  To PLL.
- psstep  out  1  To PLL; one-cycle pulse per step.
- psdone  in  1  From PLL; step-completion pulse.

Behaviour:
Reset values (rstn=0 at a psclk edge):
- All outputs 0; req_ready 0; all phase_pos 0; FSM in IDLE.
- req_ready goes to 1 on the first cycle after reset is released.

Handshake:
- A command is accepted when req_valid && req_ready.
- req_ready = (state==IDLE); it drops the cycle after acceptance.
- req_clksel, req_down and req_steps are latched on acceptance.

FSM states: IDLE, CHECK, SETUP, STEP, WAIT, GAP, FIN.
- IDLE -> CHECK on acceptance.
- CHECK, error checks in priority order:
  - clksel > 6 -> FIN with err 1.
  - else pll_lock == 0 -> FIN with err 2.
  - else steps == 0 -> FIN with no error; no psstep is issued.
  - else -> SETUP.
- SETUP: drive psclksel and psdown from the latched values; hold them stable until FIN.
- SETUP -> STEP after 1 cycle.
- STEP: psstep = 1 for exactly one cycle; load the timeout counter with DONE_TMO; -> WAIT.
- WAIT, on psdone:
  - Position update: +1 if psdown, else -1, modulo PHASE_STEPS (63+1 -> 0, 0-1 -> 63).
  - Decrement the remaining-step count; -> GAP.
- WAIT, on timeout counter reaching 0 with no psdone: -> FIN with err 3; the position is not updated.
- GAP: wait GAP_CYC cycles, then:
  - remaining == 0 -> FIN.
  - pll_lock == 0 -> FIN with err 2.
  - else -> STEP.
- FIN: pulse cmd_done with cmd_err/err_code; psclksel and psdown return to 0; -> IDLE.

Latency:
- Zero-step command: acceptance to cmd_done is 2 cycles.
- Each step costs 1 (STEP) + psdone wait + GAP_CYC cycles, plus a fixed 3 cycles of overhead.

Boundary and simultaneous events:
- pll_lock dropping during WAIT does not abort; the in-flight step completes, and the abort happens in GAP.
- psdone arriving in the same cycle the timeout reaches 0 counts as success.
- psdone outside WAIT is ignored; no position change.
- req_valid while busy is ignored; req_ready is 0.
- rstn low mid-command: immediate return to IDLE, positions cleared, psstep deasserted; no cmd_done is emitted.

Optional Feature:
- Macro PLL_PS_DONE_SYNC_EN.
- Defined: psdone passes through a 2-flop synchronizer followed by a rising-edge detect before FSM use. This adds 3 cycles of psdone latency, for a PLL whose psdone is asynchronous to psclk.
- Not defined: psdone is sampled directly as a single-cycle synchronous pulse.

Decomposition:
- Shared package pll_ps_pkg holds:
  - FSM state enum.
  - Error code constants: ERR_NONE, ERR_CLKSEL, ERR_NOLOCK, ERR_TMO.
  - Constant NUM_CLKC = 7.
- One sub-module, pll_ps_done_sync: synchronizer plus edge detect, instantiated only under PLL_PS_DONE_SYNC_EN.

Test Plan:
- Reset, then a command for clksel=2, down=1, steps=3, with the PLL model returning psdone 4 cycles after each psstep -> exactly 3 psstep pulses, psclksel=2 and psdown=1 held throughout, phase_pos[2]=3, cmd_done with err 0.
- Channel 0 at position 0, command up, steps=1 -> phase_pos[0]=63. Then command down, steps=1 -> phase_pos[0]=0.
- steps=0 -> cmd_done 2 cycles after acceptance, no psstep. clksel=7 -> cmd_done with err_code 1, no psstep.
- PLL model never asserts psdone -> single psstep, then cmd_done with err_code 3 exactly DONE_TMO cycles after it; position unchanged.
- pll_lock dropped during WAIT of step 2 of 5 -> step 2 completes (position +2), cmd_done with err_code 2, no third psstep.
- rstn pulsed low mid-WAIT -> all outputs 0 next cycle, no cmd_done, req_ready=1 after reset is released.
